// File: rtl/spi_pkg.sv
// Shared SPI definitions: scheduler state encoding, default word width and
// a small sizing helper, shared with the shifter's testbench.
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_ACK   = 3'd5
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin picker: first set request at or after rr_ptr (wrapping).
// The pointer moves to one past the owner when a transaction is retired.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (adv)
            rr_ptr <= (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
    end

    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any          = 1'b1;
                grant_idx    = jj;
                grant_oh[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Shares one SPI shifter among NUM_REQ requesters: arbitrate, assert the
// owner's chip select, start the shifter, wait for its done edge, then ack.
module spi_tx_scheduler
    import spi_pkg::*;
#(
    parameter int WIDTH    = SPI_WIDTH,
    parameter int NUM_REQ  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       cs_n,
    output logic [WIDTH-1:0]         shf_data,
    output logic                     shf_init,
    input  logic                     shf_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, TIMEOUT) + 1);

    spi_state_t         state, nstate;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] owner_oh;
    logic [WIDTH-1:0]   word;
    logic               err_flag;
    logic               done_prev;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   pick_word;
    logic               done_edge;
    logic               timed_out;

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .adv       (state == ST_ACK),
        .adv_idx   (owner),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_oh[i])
                pick_word = pick_word | req_data[i*WIDTH +: WIDTH];
    end

    // done is a sticky level from the shifter, so only a rising edge counts
    assign done_edge = shf_done & ~done_prev;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));
    assign owner_oh  = NUM_REQ'(1) << owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            word      <= '0;
            err_flag  <= 1'b0;
            done_prev <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= nstate;
            if (nstate != state || state == ST_IDLE || state == ST_ACK)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            case (state)
                ST_IDLE: if (pick_any) begin
                    owner    <= pick_idx;
                    word     <= pick_word;
                    err_flag <= (pick_word == '0);
                end
                ST_START: done_prev <= shf_done;
                ST_WAIT: begin
                    done_prev <= shf_done;
                    if (timed_out && !done_edge)
                        err_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (pick_any) nstate = (pick_word == '0) ? ST_ACK : ST_SETUP;
            ST_SETUP: if (cnt == CNT_W'(CS_SETUP - 1)) nstate = ST_START;
            ST_START: nstate = ST_WAIT;
            ST_WAIT:  if (done_edge || timed_out) nstate = ST_HOLD;
            ST_HOLD:  if (cnt == CNT_W'(CS_HOLD - 1)) nstate = ST_ACK;
            ST_ACK:   nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        ack      = '0;
        err      = 1'b0;
        cs_n     = '1;
        shf_data = '0;
        shf_init = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_SETUP, ST_START, ST_WAIT, ST_HOLD: begin
                grant    = owner_oh;
                cs_n     = ~owner_oh;
                shf_data = word;
                shf_init = (state == ST_START);
            end
            ST_ACK: begin
                ack = owner_oh;
                err = err_flag;
            end
            default: ;
        endcase
    end

endmodule
